// File: rtl/gbe_udp_pktgen_pkg.sv
// Shared definitions for the UDP packet generator and its RX-side checker:
// state encoding, frame geometry constants and the payload byte function.
package gbe_udp_pktgen_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Frame geometry: 4-byte sequence header, at least one payload byte
  localparam int HDR_BYTES = 4;
  localparam int MIN_LEN   = 5;

  // Destination resolved at frame start and held for the whole frame
  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } pktgen_dest_t;

  // Payload byte k of a frame carrying sequence number seq
  function automatic logic [7:0] payload_byte(input logic [7:0] k,
                                              input logic [7:0] seq_lsb);
    return k ^ seq_lsb;
  endfunction

  // Header byte sel (0 = most significant) of the sequence number
  function automatic logic [7:0] hdr_byte(input logic [31:0] seq,
                                          input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = seq[31:24];
      2'd1:    b = seq[23:16];
      2'd2:    b = seq[15:8];
      2'd3:    b = seq[7:0];
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gbe_udp_pktgen_gap_timer.sv
// Loadable down-counter with a zero flag; times the idle gap after each frame.
module pktgen_gap_timer
  import gbe_udp_pktgen_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load takes priority over decrement; the counter stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/gbe_udp_pktgen.sv
// Application-side UDP traffic source for the gbe_udp app_tx interface.
// Emits byte-wide frames (4-byte sequence header + deterministic payload),
// throttles on app_tx_afull, and counts sent frames and overflow pulses.
module gbe_udp_pktgen
  import gbe_udp_pktgen_pkg::*;
#(
  parameter logic [31:0] DEST_IP   = 32'hC0A84001,
  parameter logic [15:0] DEST_PORT = 16'hBEEF,
  parameter int          LEN_W     = 16
) (
  input  logic             app_clk,
  input  logic             app_rst,
  input  logic             cfg_en,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [LEN_W-1:0] cfg_gap,
  input  logic [31:0]      cfg_num_pkts,
  input  logic [31:0]      cfg_dest_ip,
  input  logic [15:0]      cfg_dest_port,
  output logic [7:0]       app_tx_data,
  output logic             app_tx_dvld,
  output logic             app_tx_eof,
  output logic [31:0]      app_tx_destip,
  output logic [15:0]      app_tx_destport,
  input  logic             app_tx_afull,
  input  logic             app_tx_overflow,
  output logic             stat_busy,
  output logic             stat_done,
  output logic [31:0]      stat_pkt_cnt,
  output logic [15:0]      stat_ovf_cnt
);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] gap_r;
  logic [LEN_W-1:0] idx_r;
  logic [LEN_W-1:0] len_clamp_s;
  pktgen_dest_t     dest_r;
  pktgen_dest_t     dest_sel_s;
  logic [31:0]      seq_r;
  logic [31:0]      pkt_cnt_r;
  logic             done_r;
  logic [15:0]      ovf_cnt_r;
  logic [7:0]       data_r;
  logic             dvld_r;
  logic             eof_r;
  logic [7:0]       byte_s;
  logic [7:0]       pay_k_s;
  logic             in_frame_s;
  logic             issue_s;
  logic             last_s;
  logic             eof_issue_s;
  logic             gap_zero_s;
  logic             done_hit_s;

  // A byte leaves only from HDR/PAY and only when the downstream buffer has room
  assign in_frame_s  = (state_r == ST_HDR) || (state_r == ST_PAY);
  assign issue_s     = in_frame_s && !app_tx_afull;
  assign last_s      = (idx_r == (len_r - LEN_W'(1)));
  assign eof_issue_s = issue_s && (state_r == ST_PAY) && last_s;

  // Payload index counts from the first byte after the header (mod 256)
  assign pay_k_s = idx_r[7:0] - 8'(HDR_BYTES);

  // Frame-start configuration: clamp length, resolve zero destinations
  assign len_clamp_s    = (cfg_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : cfg_len;
  assign dest_sel_s.ip   = (cfg_dest_ip == 32'd0) ? DEST_IP : cfg_dest_ip;
  assign dest_sel_s.port = (cfg_dest_port == 16'd0) ? DEST_PORT : cfg_dest_port;

  // Packet budget reached (counter already includes the frame just ended)
  assign done_hit_s = (cfg_num_pkts != 32'd0) && (pkt_cnt_r == cfg_num_pkts);

  assign busy_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_HDR) ||
                      (state_nxt_s == ST_PAY)  || (state_nxt_s == ST_GAP);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_en && !done_r) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_HDR;
      end
      ST_HDR: begin
        if (issue_s && (idx_r == LEN_W'(HDR_BYTES - 1))) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_PAY: begin
        if (eof_issue_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_PAY;
        end
      end
      ST_GAP: begin
        if (!gap_zero_s) begin
          state_nxt_s = ST_GAP;
        end else if (done_hit_s) begin
          state_nxt_s = ST_DONE;
        end else if (cfg_en) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!cfg_en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Byte to issue at the coming edge: header from seq, otherwise payload
  always_comb begin
    byte_s = 8'h00;
    if (state_r == ST_HDR) begin
      byte_s = hdr_byte(seq_r, idx_r[1:0]);
    end else begin
      byte_s = payload_byte(pay_k_s, seq_r[7:0]);
    end
  end

  // FSM state register and busy flag
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Per-frame parameters captured in LOAD so cfg changes wait for the next frame
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      len_r  <= {LEN_W{1'b0}};
      gap_r  <= {LEN_W{1'b0}};
      dest_r <= {32'd0, 16'd0};
    end else if (state_r == ST_LOAD) begin
      len_r  <= len_clamp_s;
      gap_r  <= cfg_gap;
      dest_r <= dest_sel_s;
    end else begin
      len_r  <= len_r;
      gap_r  <= gap_r;
      dest_r <= dest_r;
    end
  end

  // Byte index within the frame, header included
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      idx_r <= {LEN_W{1'b0}};
    end else if (state_r == ST_LOAD) begin
      idx_r <= {LEN_W{1'b0}};
    end else if (issue_s) begin
      idx_r <= idx_r + LEN_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Registered app_tx byte stream; data and eof hold on stalled cycles
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      data_r <= 8'h00;
      dvld_r <= 1'b0;
      eof_r  <= 1'b0;
    end else if (issue_s) begin
      data_r <= byte_s;
      dvld_r <= 1'b1;
      eof_r  <= eof_issue_s;
    end else begin
      data_r <= data_r;
      dvld_r <= 1'b0;
      eof_r  <= eof_r;
    end
  end

  // Sequence number, completed-frame count and done flag
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      seq_r     <= 32'd0;
      pkt_cnt_r <= 32'd0;
      done_r    <= 1'b0;
    end else if ((state_r == ST_DONE) && !cfg_en) begin
      seq_r     <= 32'd0;
      pkt_cnt_r <= 32'd0;
      done_r    <= 1'b0;
    end else begin
      if (eof_issue_s) begin
        seq_r     <= seq_r + 32'd1;
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end else begin
        seq_r     <= seq_r;
        pkt_cnt_r <= pkt_cnt_r;
      end
      if ((state_r == ST_GAP) && (state_nxt_s == ST_DONE)) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Saturating count of downstream overflow pulses; frames are never aborted
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      ovf_cnt_r <= 16'd0;
    end else if (app_tx_overflow && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  // Inter-frame gap, armed as the eof byte is issued
  pktgen_gap_timer #(
    .W (LEN_W)
  ) u_gap_timer (
    .clk      (app_clk),
    .rst      (app_rst),
    .load     (eof_issue_s),
    .load_val (gap_r),
    .dec      (state_r == ST_GAP),
    .zero     (gap_zero_s)
  );

  assign app_tx_data     = data_r;
  assign app_tx_dvld     = dvld_r;
  assign app_tx_eof      = eof_r;
  assign app_tx_destip   = dest_r.ip;
  assign app_tx_destport = dest_r.port;
  assign stat_busy       = busy_r;
  assign stat_done       = done_r;
  assign stat_pkt_cnt    = pkt_cnt_r;
  assign stat_ovf_cnt    = ovf_cnt_r;

endmodule

// File: tb/tb_gbe_udp_pktgen.sv
// Self-checking bench for gbe_udp_pktgen: expected frame bytes are queued
// when a run is configured and popped as the DUT emits bytes.
module tb_gbe_udp_pktgen;

  logic        app_clk = 1'b0;
  logic        app_rst;
  logic        cfg_en;
  logic [15:0] cfg_len;
  logic [15:0] cfg_gap;
  logic [31:0] cfg_num_pkts;
  logic [31:0] cfg_dest_ip;
  logic [15:0] cfg_dest_port;
  logic [7:0]  app_tx_data;
  logic        app_tx_dvld;
  logic        app_tx_eof;
  logic [31:0] app_tx_destip;
  logic [15:0] app_tx_destport;
  logic        app_tx_afull;
  logic        app_tx_overflow;
  logic        stat_busy;
  logic        stat_done;
  logic [31:0] stat_pkt_cnt;
  logic [15:0] stat_ovf_cnt;

  always #5 app_clk = ~app_clk;

  gbe_udp_pktgen dut (
    .app_clk         (app_clk),
    .app_rst         (app_rst),
    .cfg_en          (cfg_en),
    .cfg_len         (cfg_len),
    .cfg_gap         (cfg_gap),
    .cfg_num_pkts    (cfg_num_pkts),
    .cfg_dest_ip     (cfg_dest_ip),
    .cfg_dest_port   (cfg_dest_port),
    .app_tx_data     (app_tx_data),
    .app_tx_dvld     (app_tx_dvld),
    .app_tx_eof      (app_tx_eof),
    .app_tx_destip   (app_tx_destip),
    .app_tx_destport (app_tx_destport),
    .app_tx_afull    (app_tx_afull),
    .app_tx_overflow (app_tx_overflow),
    .stat_busy       (stat_busy),
    .stat_done       (stat_done),
    .stat_pkt_cnt    (stat_pkt_cnt),
    .stat_ovf_cnt    (stat_ovf_cnt)
  );

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] gap;
    logic [31:0] num;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [31:0] exp_ip;
    logic [15:0] exp_port;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  lit  [16];
  logic [8:0]  sb_q [$];
  logic [8:0]  exp_b;
  int          n_vec = 0;
  int          n_err = 0;
  int          byte_cnt = 0;
  int          eof_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference frame: big-endian seq header, then (k ^ seq[7:0]) payload
  function automatic void push_frame(input logic [15:0] len, input logic [31:0] seq);
    int eff;
    logic [7:0] b;
    eff = (len < 16'd5) ? 5 : int'(len);
    for (int i = 0; i < eff; i++) begin
      if (i < 4) b = 8'(seq >> (8 * (3 - i)));
      else       b = 8'(i - 4) ^ seq[7:0];
      sb_q.push_back({(i == eff - 1), b});
    end
  endfunction

  // Scoreboard: every valid byte must match the head of the expected queue
  always @(negedge app_clk) begin
    if (!app_rst && app_tx_dvld) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got eof=%0b data=%02h, want no byte", app_tx_eof, app_tx_data);
      end else begin
        exp_b = sb_q.pop_front();
        if ({app_tx_eof, app_tx_data} !== exp_b) begin
          n_err++;
          $display("FAIL byte_%0d: got eof=%0b data=%02h, want eof=%0b data=%02h",
                   byte_cnt, app_tx_eof, app_tx_data, exp_b[8], exp_b[7:0]);
        end
      end
      byte_cnt++;
      if (app_tx_eof) eof_cnt++;
    end
  end

  task automatic do_reset();
    cfg_en = 1'b0;
    app_tx_afull = 1'b0;
    app_tx_overflow = 1'b0;
    app_rst = 1'b1;
    repeat (2) @(posedge app_clk);
    #1;
    chk("reset_tx", {6'd0, app_tx_dvld, app_tx_eof, app_tx_data, app_tx_destport, app_tx_destip}, 64'd0);
    chk("reset_stat", {14'd0, stat_busy, stat_done, stat_pkt_cnt, stat_ovf_cnt}, 64'd0);
    sb_q.delete();
    byte_cnt = 0;
    eof_cnt = 0;
    app_rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && stat_done !== 1'b1; i++) @(posedge app_clk);
    #1;
  endtask

  task automatic end_run(input string name);
    cfg_en = 1'b0;
    repeat (2) @(posedge app_clk);
    #1;
    chk({name, "_cleared"}, {31'd0, stat_done, stat_pkt_cnt}, 64'd0);
  endtask

  initial begin
    vecs[0] = {16'd3,  16'd0, 32'd1, 32'd0,         16'd0,      32'hC0A84001, 16'hBEEF};
    vecs[1] = {16'd5,  16'd1, 32'd2, 32'h0A000001,  16'h1234,   32'h0A000001, 16'h1234};
    vecs[2] = {16'd12, 16'd0, 32'd3, 32'd0,         16'h0050,   32'hC0A84001, 16'h0050};
    vecs[3] = {16'd4,  16'd3, 32'd1, 32'h11223344,  16'd0,      32'h11223344, 16'hBEEF};
    lit = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03,
            8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h03, 8'h02};
    cfg_len = 16'd8; cfg_gap = 16'd0; cfg_num_pkts = 32'd0;
    cfg_dest_ip = 32'd0; cfg_dest_port = 16'd0;

    // Two literal frames with default destination
    do_reset();
    cfg_len = 16'd8; cfg_gap = 16'd2; cfg_num_pkts = 32'd2;
    for (int i = 0; i < 16; i++) sb_q.push_back({(i == 7 || i == 15), lit[i]});
    @(posedge app_clk); #1 cfg_en = 1'b1;
    wait_done(500);
    chk("tp1_done", {31'd0, stat_done}, 64'd1);
    chk("tp1_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd2);
    chk("tp1_dest", {app_tx_destip, app_tx_destport}, {16'd0, 32'hC0A84001, 16'hBEEF});
    chk("tp1_drain", sb_q.size(), 64'd0);
    end_run("tp1");

    // Table of lengths, gaps, budgets and destinations
    for (int v = 0; v < 4; v++) begin
      do_reset();
      cfg_len = vecs[v].len; cfg_gap = vecs[v].gap; cfg_num_pkts = vecs[v].num;
      cfg_dest_ip = vecs[v].dip; cfg_dest_port = vecs[v].dport;
      for (int f = 0; f < int'(vecs[v].num); f++) push_frame(vecs[v].len, 32'(f));
      @(posedge app_clk); #1 cfg_en = 1'b1;
      wait_done(2000);
      chk($sformatf("vec%0d_done", v), {31'd0, stat_done}, 64'd1);
      chk($sformatf("vec%0d_pkt_cnt", v), {32'd0, stat_pkt_cnt}, {32'd0, vecs[v].num});
      chk($sformatf("vec%0d_dest", v), {16'd0, app_tx_destip, app_tx_destport},
          {16'd0, vecs[v].exp_ip, vecs[v].exp_port});
      chk($sformatf("vec%0d_drain", v), sb_q.size(), 64'd0);
      end_run($sformatf("vec%0d", v));
    end
    cfg_dest_ip = 32'd0; cfg_dest_port = 16'd0;

    // 10-cycle afull stall in the middle of a 64-byte payload
    do_reset();
    cfg_len = 16'd64; cfg_gap = 16'd0; cfg_num_pkts = 32'd1;
    push_frame(16'd64, 32'd0);
    @(posedge app_clk); #1 cfg_en = 1'b1;
    for (int i = 0; i < 500 && byte_cnt < 20; i++) @(posedge app_clk);
    #1 app_tx_afull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge app_clk); #1;
      chk("stall_dvld", {63'd0, app_tx_dvld}, 64'd0);
    end
    app_tx_afull = 1'b0;
    wait_done(500);
    chk("stall_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd1);
    chk("stall_bytes", byte_cnt, 64'd64);
    chk("stall_drain", sb_q.size(), 64'd0);
    end_run("stall");

    // afull toggling every cycle
    do_reset();
    cfg_len = 16'd16; cfg_gap = 16'd0; cfg_num_pkts = 32'd1;
    push_frame(16'd16, 32'd0);
    @(posedge app_clk); #1 cfg_en = 1'b1;
    for (int i = 0; i < 400 && stat_done !== 1'b1; i++) begin
      @(posedge app_clk); #1 app_tx_afull = ~app_tx_afull;
    end
    app_tx_afull = 1'b0;
    wait_done(100);
    chk("toggle_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd1);
    chk("toggle_drain", sb_q.size(), 64'd0);
    end_run("toggle");

    // cfg_en dropped during the header: frame completes, then idle
    do_reset();
    cfg_len = 16'd32; cfg_gap = 16'd2; cfg_num_pkts = 32'd0;
    push_frame(16'd32, 32'd0);
    @(posedge app_clk); #1 cfg_en = 1'b1;
    for (int i = 0; i < 200 && byte_cnt < 2; i++) @(posedge app_clk);
    #1 cfg_en = 1'b0;
    for (int i = 0; i < 200 && eof_cnt < 1; i++) @(posedge app_clk);
    repeat (10) @(posedge app_clk);
    #1;
    chk("endrop_busy", {63'd0, stat_busy}, 64'd0);
    chk("endrop_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd1);
    chk("endrop_eofs", eof_cnt, 64'd1);
    chk("endrop_drain", sb_q.size(), 64'd0);

    // Reset at payload byte 10 of the second frame
    do_reset();
    cfg_len = 16'd32; cfg_gap = 16'd0; cfg_num_pkts = 32'd0;
    push_frame(16'd32, 32'd0);
    push_frame(16'd32, 32'd1);
    @(posedge app_clk); #1 cfg_en = 1'b1;
    for (int i = 0; i < 500 && byte_cnt < 46; i++) @(posedge app_clk);
    #1;
    chk("midrst_pre_cnt", {32'd0, stat_pkt_cnt}, 64'd1);
    app_rst = 1'b1;
    @(posedge app_clk); #1;
    chk("midrst_out", {29'd0, app_tx_dvld, app_tx_eof, stat_pkt_cnt}, 64'd0);
    sb_q.delete();
    byte_cnt = 0;
    eof_cnt = 0;
    cfg_num_pkts = 32'd1;
    push_frame(16'd32, 32'd0);
    app_rst = 1'b0;
    wait_done(500);
    chk("midrst_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd1);
    chk("midrst_drain", sb_q.size(), 64'd0);
    end_run("midrst");

    // Overflow pulses during an unlimited run, then saturation
    do_reset();
    cfg_len = 16'd8; cfg_gap = 16'd3; cfg_num_pkts = 32'd0;
    for (int f = 0; f < 5; f++) push_frame(16'd8, 32'(f));
    @(posedge app_clk); #1 cfg_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      repeat (7 + 2 * p) @(posedge app_clk);
      #1 app_tx_overflow = 1'b1;
      @(posedge app_clk);
      #1 app_tx_overflow = 1'b0;
    end
    for (int i = 0; i < 500 && eof_cnt < 5; i++) @(posedge app_clk);
    #1 cfg_en = 1'b0;
    repeat (10) @(posedge app_clk);
    #1;
    chk("ovf_cnt", {48'd0, stat_ovf_cnt}, 64'd3);
    chk("ovf_pkt_cnt", {32'd0, stat_pkt_cnt}, 64'd5);
    chk("ovf_drain", sb_q.size(), 64'd0);
    chk("ovf_busy", {63'd0, stat_busy}, 64'd0);
    app_tx_overflow = 1'b1;
    repeat (65540) @(posedge app_clk);
    #1 app_tx_overflow = 1'b0;
    chk("ovf_sat", {48'd0, stat_ovf_cnt}, 64'hFFFF);
    @(posedge app_clk); #1 app_tx_overflow = 1'b1;
    @(posedge app_clk); #1 app_tx_overflow = 1'b0;
    @(posedge app_clk); #1;
    chk("ovf_sat_hold", {48'd0, stat_ovf_cnt}, 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gbe_udp_pktgen.md
Name: gbe_udp_pktgen

Overview:
Application-side UDP traffic source that drives the gbe_udp app_tx interface in the app_clk domain. It emits byte-wide frames with a 4-byte sequence header and a deterministic payload, and it throttles on app_tx_afull. It counts sent frames and overflow events so software and benches can verify end-to-end delivery through the MAC loopback. It sits directly upstream of gbe_udp.

Parameters:
DEST_IP, 32'hC0A84001, default destination IP when cfg_dest_ip is zero
DEST_PORT, 16'hBEEF, default destination port when cfg_dest_port is zero
LEN_W, 16, width of frame-length and gap fields

Ports:
app_clk  in  1  sole clock
app_rst  in  1  synchronous, active-high reset
cfg_en  in  1  level enable; start or continue generating frames
cfg_len  in  LEN_W  frame length in bytes, header included; sampled at frame start
cfg_gap  in  LEN_W  idle cycles between frames; sampled at frame start
cfg_num_pkts  in  32  frames to send; 0 means unlimited
cfg_dest_ip  in  32  destination IP; 0 selects DEST_IP
cfg_dest_port  in  16  destination port; 0 selects DEST_PORT
app_tx_data  out  8  frame byte
app_tx_dvld  out  1  byte valid
app_tx_eof  out  1  last byte of frame, qualified by dvld
app_tx_destip  out  32  destination IP, held constant for the frame
app_tx_destport  out  16  destination port, held constant for the frame
app_tx_afull  in  1  gbe_udp TX buffer almost full
app_tx_overflow  in  1  gbe_udp TX buffer overflow pulse
stat_busy  out  1  high from frame start to end of gap
stat_done  out  1  cfg_num_pkts frames sent
stat_pkt_cnt  out  32  frames completed, counted at eof
stat_ovf_cnt  out  16  overflow pulses, saturating

Behaviour:
- Reset values: all outputs 0. FSM enters IDLE. Sequence number is 0.
- All app_tx_* outputs are registered. A byte appears one cycle after the edge at which it is issued.
- A byte is issued at an edge only if the FSM is in HDR or PAY and app_tx_afull is low at that edge. Otherwise app_tx_dvld is 0 on the next cycle and data, eof and counters hold.
- FSM states:
  - IDLE -> LOAD when cfg_en=1 and stat_done=0.
  - LOAD (1 cycle): latch len = max(cfg_len, 5), gap = cfg_gap and the resolved destination. Clear the byte index. -> HDR.
  - HDR: issue seq[31:24], seq[23:16], seq[15:8], seq[7:0] in order. After the 4th byte -> PAY.
  - PAY: byte k (k from 0) = k[7:0] ^ seq[7:0]. Issue the final byte, at index len-1, with eof=1. After eof -> GAP.
  - GAP: count down the latched gap. With gap=0, exit on the cycle after eof. On exit:
    - to DONE if cfg_num_pkts != 0 and stat_pkt_cnt == cfg_num_pkts;
    - otherwise to LOAD if cfg_en=1;
    - otherwise to IDLE.
  - DONE: stat_done=1. Hold until cfg_en=0, then clear stat_done and stat_pkt_cnt, reset seq to 0, -> IDLE.
- Sequence number increments at eof issue and wraps from 2^32-1 to 0.
- Dropping cfg_en mid-frame never truncates: the frame and its gap complete, then -> IDLE.
- cfg_* changes take effect only at the next LOAD.
- Byte index is LEN_W bits. len is at most 2^LEN_W-1, so no wrap within a frame.
- If app_tx_overflow is high in the same cycle as an issue, the issue still proceeds. The frame is not aborted; the overflow is only counted. stat_ovf_cnt saturates at 16'hFFFF.
- When app_tx_afull toggles every cycle, bytes are issued only on afull-low edges. No byte is duplicated or skipped.
- app_rst mid-frame: outputs return to 0 on the next cycle. No eof is emitted for the partial frame, and the counters clear.

Decomposition:
- Shared package gbe_udp_pktgen_pkg holds:
  - the state encoding (IDLE, LOAD, HDR, PAY, GAP, DONE);
  - HDR_BYTES=4, MIN_LEN=5;
  - the payload function (index ^ seq[7:0]), reused by the RX checker.
- One natural sub-module, pktgen_gap_timer: a loadable down-counter with a zero flag, used for GAP.

Test Plan:
- cfg_len=8, gap=2, num_pkts=2, afull=0, dests=0 -> expected output:
  - frame 0: 00 00 00 00 00 01 02 03, eof on the 8th byte;
  - frame 1: 00 00 00 01 01 00 03 02;
  - destip C0A84001, destport BEEF;
  - stat_pkt_cnt=2, stat_done=1.
- cfg_len=3 -> frame clamped to 5 bytes (4 header + payload 00), eof on the 5th byte.
- afull high for 10 cycles mid-PAY with len=64 -> dvld low throughout the stall. Byte sequence is contiguous with no gaps or repeats, and there are exactly 64 bytes between SOF and eof.
- cfg_en dropped on header byte 2 of len=32 -> full 32-byte frame with eof, then IDLE. stat_pkt_cnt incremented by 1.
- app_rst asserted at PAY byte 10 -> next cycle dvld=0, eof=0, stat_pkt_cnt=0. The next frame after release starts with seq 00000000.
- 3 app_tx_overflow pulses during unlimited run -> stat_ovf_cnt=3, frames continue uninterrupted. A forced counter value of FFFF stays at FFFF on a further pulse.
